// File: rtl/apb_completer_regfile.sv
// apb_completer_regfile: APB completer with a small 32-bit register file.
//   Registers 0..NUM_REGS-2 are read/write. Register NUM_REGS-1 is a read-only
//   ID register that returns ID_VALUE. WAIT_CYCLES extra wait states (0..15)
//   are inserted before PREADY. PSLVERR flags the following accesses:
//   misaligned, out of range, or a write to the ID register.
//   Optional macro APB_PSTRB_EN adds the pstrb_i byte-strobe port.
// Ports:
//   pclk, preset_n      clock and async active-low reset
//   psel_i, penable_i   APB handshake inputs
//   pwrite_i            1 = write, 0 = read
//   paddr_i             byte address
//   pwdata_i            write data
//   pstrb_i             byte strobes (APB_PSTRB_EN only)
//   prdata_o            read data, valid while pready_o=1
//   pready_o            transfer complete, high for the single ACCESS cycle
//   pslverr_o           error response, valid while pready_o=1
//   xfer_cnt_o          completed-transfer count, wraps
module apb_completer_regfile #(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0016
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
`ifdef APB_PSTRB_EN
  input  logic [3:0]        pstrb_i,
`endif
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic [15:0]       xfer_cnt_o
);

  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned RSEL_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] ID_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] NUM_IDX = IDX_W'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       regs [NUM_REGS-1];
  logic [15:0]       xfer_cnt_q;
  logic [31:0]       prdata_q;
  logic              pready_q;
  logic              pslverr_q;

  logic [IDX_W-1:0]  idx;
  logic [RSEL_W-1:0] rsel;
  logic              err;
  logic [31:0]       rd_val;
  logic [31:0]       wmask;
  logic              setup_hit;

`ifdef APB_PSTRB_EN
  logic [3:0] strb_q;
  assign wmask = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};
`else
  assign wmask = '1;
`endif

  // Decode runs on the latched request, which is stable from SETUP onward.
  assign idx       = addr_q[ADDR_W-1:2];
  assign rsel      = idx[RSEL_W-1:0];
  assign err       = (addr_q[1:0] != 2'b00) || (idx >= NUM_IDX) || (wr_q && (idx == ID_IDX));
  assign rd_val    = (idx == ID_IDX) ? ID_VALUE : regs[rsel];
  assign setup_hit = (state_q == S_IDLE) && psel_i && !penable_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (psel_i && !penable_i) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (!psel_i) begin
          state_d = S_IDLE;
        end else if (penable_i) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!psel_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
`ifdef APB_PSTRB_EN
      strb_q     <= '0;
`endif
      regs       <= '{default: '0};
      xfer_cnt_q <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (setup_hit) begin
        addr_q  <= paddr_i;
        wr_q    <= pwrite_i;
        wdata_q <= pwdata_i;
`ifdef APB_PSTRB_EN
        strb_q  <= pstrb_i;
`endif
      end
      // Response registers are loaded on the edge entering ACCESS so they
      // are valid for exactly that cycle and cleared on the way out.
      pready_q  <= (state_d == S_ACCESS);
      pslverr_q <= (state_d == S_ACCESS) && err;
      prdata_q  <= ((state_d == S_ACCESS) && !wr_q && !err) ? rd_val : '0;
      if (state_q == S_ACCESS) begin
        xfer_cnt_q <= xfer_cnt_q + 16'd1;
        if (wr_q && !err) begin
          regs[rsel] <= (regs[rsel] & ~wmask) | (wdata_q & wmask);
        end
      end
    end
  end

  assign prdata_o   = prdata_q;
  assign pready_o   = pready_q;
  assign pslverr_o  = pslverr_q;
  assign xfer_cnt_o = xfer_cnt_q;

endmodule

// File: doc/apb_completer_regfile.md
Name: apb_completer_regfile

Overview:
- APB completer (slave) end of the team's APB link. It responds to transfers driven by the existing APB master.
- Holds a small 32-bit register file with a read-only ID register.
- Inserts a configurable number of wait states and flags bad accesses with PSLVERR.
- Sits behind the master inside the top level and replaces the ad-hoc slave model.

Parameters:
- NUM_REGS, 4: number of 32-bit registers. Register NUM_REGS-1 is the read-only ID register.
- ADDR_W, 8: paddr_i width (byte address).
- WAIT_CYCLES, 0: extra wait states inserted before PREADY. Legal range 0..15.
- ID_VALUE, 32'hA5B0_0016: constant returned by the ID register.

Ports:
- pclk  in  1  APB clock; all state on the rising edge.
- preset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- psel_i  in  1  APB PSEL.
- penable_i  in  1  APB PENABLE.
- pwrite_i  in  1  1 = write, 0 = read.
- paddr_i  in  ADDR_W  byte address.
- pwdata_i  in  32  write data.
- pstrb_i  in  4  byte strobes; present only with APB_PSTRB_EN.
- prdata_o  out  32  read data; valid while pready_o=1 on a read.
- pready_o  out  1  transfer-complete strobe.
- pslverr_o  out  1  error response; valid only while pready_o=1.
- xfer_cnt_o  out  16  count of completed transfers (OK and error); wraps.

Behaviour:
- Reset (async, preset_n=0): state IDLE; all registers 0; prdata_o=0; pready_o=0; pslverr_o=0; xfer_cnt_o=0. Reset during a transfer aborts it and nothing is committed.
- FSM states and transitions (sampled at posedge):
  - IDLE -> SETUP when psel_i=1 and penable_i=0. On this edge, latch paddr_i, pwrite_i and pwdata_i (and pstrb_i if enabled).
  - SETUP -> ACCESS when psel_i=1, penable_i=1 and WAIT_CYCLES=0.
  - SETUP -> WAIT when psel_i=1, penable_i=1 and WAIT_CYCLES>0. Load wait counter = WAIT_CYCLES-1.
  - SETUP stays SETUP while psel_i=1 and penable_i=0.
  - WAIT: counter decrements each cycle; -> ACCESS when the counter is 0.
  - ACCESS -> IDLE unconditionally.
  - Back-to-back transfers are accepted from IDLE on the following setup cycle.
- Outputs are registered. pready_o=1 exactly for the single cycle spent in ACCESS.
- Latency: pready_o rises on the (2+WAIT_CYCLES)-th cycle after the setup cycle, i.e. the first access-phase cycle is never ready.
- Address decode:
  - idx = paddr_i[ADDR_W-1:2].
  - Error (pslverr_o=1) if paddr_i[1:0]!=0, idx>=NUM_REGS, or a write targets the ID register.
  - On error, no register changes and prdata_o=0.
- Write: committed at the posedge that ends the ACCESS cycle. prdata_o=0 during writes.
- Read: prdata_o = register[idx], or ID_VALUE for the ID register, during the ACCESS cycle. prdata_o returns to 0 otherwise.
- xfer_cnt_o increments at the end of every ACCESS cycle and wraps 16'hFFFF -> 0.
- Abort: if psel_i=0 while in SETUP or WAIT, go to IDLE. No commit, no pready_o, no count change.
- penable_i=1 seen in IDLE without a preceding setup is ignored.
- Latched pwdata is used; changes on pwdata_i after the setup cycle have no effect.

Optional Feature:
- APB_PSTRB_EN defined:
  - pstrb_i port exists.
  - A write updates only the bytes whose strobe bit is 1.
  - pstrb_i=4'b0000 completes with pslverr_o=0 and leaves the register unchanged.
  - Strobes are ignored on reads.
- Not defined: no pstrb_i port; every write updates all 32 bits.

Test Plan:
- Reset with all inputs idle -> all outputs 0.
  - Write 32'h1234abcd to addr 0x00, then read 0x00 -> prdata_o=32'h1234abcd, pslverr_o=0, xfer_cnt_o=2.
- WAIT_CYCLES=2: read addr 0x04 -> pready_o first high 4 cycles after the setup cycle; high for exactly 1 cycle.
- Read addr 0x10 -> pslverr_o=1, prdata_o=0.
  - Write 32'hFFFF_FFFF to 0x0C (ID register) -> pslverr_o=1.
  - Subsequent read of 0x0C -> 32'hA5B0_0016.
  - xfer_cnt_o still increments on both error transfers.
- Start a write of 32'h5678ef01 to 0x08 and drop psel_i in WAIT (WAIT_CYCLES=3) -> no pready_o; read of 0x08 returns the old value; count unchanged.
  - Repeat with preset_n pulsed low mid-transfer -> everything returns to 0.
- APB_PSTRB_EN: reg 0 = 32'h1234abcd; write 32'hFFFFFFFF with pstrb=4'b0101 -> read gives 32'h12FFabFF.
  - pstrb=0 write -> value unchanged, pslverr_o=0.
